// File: rtl/child_dispatch_sequencer.sv
// Issues one start pulse at a time to NUM_CHILD children in index order, waiting
// for each child's done and aborting the whole sequence if any child times out.
module child_dispatch_sequencer #(
    parameter int NUM_CHILD      = 5,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8,
    parameter int IDX_W          = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic [NUM_CHILD-1:0] child_start_o,
    input  logic [NUM_CHILD-1:0] child_done_i,
    output logic [IDX_W-1:0]     active_idx_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [IDX_W-1:0]     err_idx_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHILD - 1);
    localparam logic [CNT_W-1:0] TIMER_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     timer_q, timer_d;
    logic                 err_q, err_d;
    logic [IDX_W-1:0]     err_idx_q, err_idx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [NUM_CHILD-1:0] child_start_q, child_start_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    idx_d     = '0;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done on the awaited child takes priority over the final timeout cycle.
                if (child_done_i[idx_q]) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end else if (timer_q == TIMER_MAX) begin
                    err_d     = 1'b1;
                    err_idx_d = idx_q;
                    state_d   = S_FINISH;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_FINISH);
        child_start_d = '0;
        if (state_d == S_ISSUE) begin
            child_start_d = NUM_CHILD'(1) << idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            timer_q       <= '0;
            err_q         <= 1'b0;
            err_idx_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            child_start_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            err_q         <= err_d;
            err_idx_q     <= err_idx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            child_start_q <= child_start_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign err_idx_o     = err_idx_q;
    assign active_idx_o  = idx_q;
    assign child_start_o = child_start_q;

endmodule

// File: tb/tb_child_dispatch_sequencer.sv
// Table-driven bench for child_dispatch_sequencer (5 children, timeout of 4 cycles),
// plus a reactive sequence that answers each start pulse and measures total latency.
module tb_child_dispatch_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic       busy_o;
    logic [4:0] child_start_o;
    logic [4:0] child_done_i;
    logic [2:0] active_idx_o;
    logic       done_o;
    logic       err_o;
    logic [2:0] err_idx_o;

    int errors = 0;
    int checks = 0;

    child_dispatch_sequencer #(
        .NUM_CHILD(5),
        .TIMEOUT_CYCLES(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start_i),
        .busy_o(busy_o),
        .child_start_o(child_start_o),
        .child_done_i(child_done_i),
        .active_idx_o(active_idx_o),
        .done_o(done_o),
        .err_o(err_o),
        .err_idx_o(err_idx_o)
    );

    always #5 clk = ~clk;

    // Expected word: {busy, child_start[4:0], done, err, err_idx[2:0], active_idx[2:0]}
    typedef struct {
        logic        rst;
        logic        start;
        logic [4:0]  cdone;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic r, input logic s, input logic [4:0] cd,
                     input logic b, input logic [4:0] cs, input logic dn,
                     input logic e, input logic [2:0] ei, input logic [2:0] ai);
        vec_t t;
        t.rst   = r;
        t.start = s;
        t.cdone = cd;
        t.exp   = {b, cs, dn, e, ei, ai};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [4:0] prev;
        int got;

        // Scenario 1: every child answers in its first WAIT cycle.
        v(0,1,5'h00, 0,5'h00,0,0,0,0);
        v(0,0,5'h00, 1,5'h01,0,0,0,0);
        v(0,0,5'h01, 1,5'h00,0,0,0,0);
        v(0,0,5'h00, 1,5'h02,0,0,0,1);
        v(0,0,5'h02, 1,5'h00,0,0,0,1);
        v(0,0,5'h00, 1,5'h04,0,0,0,2);
        v(0,0,5'h04, 1,5'h00,0,0,0,2);
        v(0,0,5'h00, 1,5'h08,0,0,0,3);
        v(0,0,5'h08, 1,5'h00,0,0,0,3);
        v(0,0,5'h00, 1,5'h10,0,0,0,4);
        v(0,0,5'h10, 1,5'h00,0,0,0,4);
        v(0,0,5'h00, 1,5'h00,1,0,0,4);
        // Scenario 2: child 2 never answers (other bits noisy), timeout after 4 WAIT cycles.
        v(0,1,5'h00, 0,5'h00,0,0,0,4);
        v(0,0,5'h00, 1,5'h01,0,0,0,0);
        v(0,0,5'h01, 1,5'h00,0,0,0,0);
        v(0,0,5'h00, 1,5'h02,0,0,0,1);
        v(0,0,5'h02, 1,5'h00,0,0,0,1);
        v(0,0,5'h00, 1,5'h04,0,0,0,2);
        v(0,0,5'h1b, 1,5'h00,0,0,0,2);
        v(0,0,5'h1b, 1,5'h00,0,0,0,2);
        v(0,0,5'h1b, 1,5'h00,0,0,0,2);
        v(0,0,5'h1b, 1,5'h00,0,0,0,2);
        v(0,1,5'h00, 1,5'h00,1,1,2,2);
        v(0,0,5'h00, 0,5'h00,0,1,2,2);
        // Scenario 3: restart clears err; child 1 answers in its last permitted WAIT cycle.
        v(0,1,5'h00, 0,5'h00,0,1,2,2);
        v(0,0,5'h00, 1,5'h01,0,0,0,0);
        v(0,0,5'h01, 1,5'h00,0,0,0,0);
        v(0,0,5'h00, 1,5'h02,0,0,0,1);
        v(0,0,5'h00, 1,5'h00,0,0,0,1);
        v(0,0,5'h00, 1,5'h00,0,0,0,1);
        v(0,0,5'h00, 1,5'h00,0,0,0,1);
        v(0,0,5'h02, 1,5'h00,0,0,0,1);
        // Scenario 5: reset while child_start_o[2] is high, then restart.
        v(1,0,5'h00, 1,5'h04,0,0,0,2);
        v(0,1,5'h00, 0,5'h00,0,0,0,0);
        // Scenario 4: done already high in ISSUE, noise on bit 4, starts while busy.
        v(0,0,5'h11, 1,5'h01,0,0,0,0);
        v(0,1,5'h10, 1,5'h00,0,0,0,0);
        v(0,0,5'h01, 1,5'h00,0,0,0,0);
        v(0,1,5'h00, 1,5'h02,0,0,0,1);
        v(0,0,5'h12, 1,5'h00,0,0,0,1);
        v(0,0,5'h00, 1,5'h04,0,0,0,2);
        v(0,0,5'h04, 1,5'h00,0,0,0,2);
        v(0,0,5'h00, 1,5'h08,0,0,0,3);
        v(0,0,5'h08, 1,5'h00,0,0,0,3);
        v(0,0,5'h00, 1,5'h10,0,0,0,4);
        v(0,0,5'h10, 1,5'h00,0,0,0,4);
        v(0,0,5'h00, 1,5'h00,1,0,0,4);
        v(0,0,5'h00, 0,5'h00,0,0,0,4);

        rst          = 1'b1;
        start_i      = 1'b0;
        child_done_i = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                32'({busy_o, child_start_o, done_o, err_o, err_idx_o, active_idx_o}),
                32'(vecs[i].exp));
            rst          = vecs[i].rst;
            start_i      = vecs[i].start;
            child_done_i = vecs[i].cdone;
        end

        // Reactive run: answer each start pulse on the following cycle, expect done at cycle 11.
        @(posedge clk);
        #1;
        start_i      = 1'b1;
        child_done_i = '0;
        prev         = '0;
        got          = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            if ((n % 2) == 1 && n < 10)
                chk($sformatf("react_start_c%0d", n), 32'(child_start_o), 32'(5'd1 << ((n - 1) / 2)));
            child_done_i = prev;
            prev         = child_start_o;
            if (done_o) begin
                got = n;
                break;
            end
        end
        chk("react_done_cycle", 32'(got), 32'd11);
        chk("react_err", 32'(err_o), 32'd0);
        child_done_i = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/child_dispatch_sequencer.md
Name: child_dispatch_sequencer

Overview:
- Sits directly below a generated hierarchy node that instantiates five children (inst_0..inst_4).
- Sequences a single start command to NUM_CHILD child instances, strictly in index order, one child at a time.
- Waits for each child's done before issuing the next; aborts on a per-child timeout.
- Reports overall completion and error status to the parent node.

Parameters:
- NUM_CHILD, 5, number of child instances sequenced (>=1).
- TIMEOUT_CYCLES, 255, maximum WAIT cycles per child before abort (>=1, < 2**CNT_W).
- CNT_W, 8, timeout counter width.
- IDX_W, $clog2(NUM_CHILD) (min 1), child index width.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  start request; sampled only in IDLE.
- busy_o  output  1  high in any state other than IDLE.
- child_start_o  output  NUM_CHILD  one-hot, one-cycle start pulse to the selected child.
- child_done_i  input  NUM_CHILD  per-child completion pulse or level.
- active_idx_o  output  IDX_W  index of the child currently being issued or awaited.
- done_o  output  1  one-cycle pulse when the sequence ends, on success or abort.
- err_o  output  1  sticky timeout flag; cleared on the next accepted start.
- err_idx_o  output  IDX_W  index of the child that timed out; valid while err_o=1.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values:
  - state=IDLE, idx=0, timer=0.
  - busy_o=0, child_start_o=0, active_idx_o=0, done_o=0, err_o=0, err_idx_o=0.
  - rst overrides every other input in the same cycle, including mid-sequence. No child_start_o pulse and no done_o are emitted on the cycle after reset.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - start_i=1 -> idx<=0, err_o<=0, err_idx_o<=0, go to ISSUE.
  - Otherwise stay.
- ISSUE:
  - child_start_o[idx]=1 for exactly this cycle; all other bits 0.
  - timer<=0, go to WAIT.
- WAIT:
  - child_done_i[idx]=1: if idx==NUM_CHILD-1 go to FINISH, else idx<=idx+1 and go to ISSUE.
  - Else if timer==TIMEOUT_CYCLES-1: err_o<=1, err_idx_o<=idx, go to FINISH.
  - Else timer<=timer+1.
  - WAIT therefore lasts at most TIMEOUT_CYCLES cycles.
- FINISH:
  - done_o=1 for this cycle only; go to IDLE.
  - err_o holds its value into IDLE.
- busy_o=1 in ISSUE, WAIT and FINISH.
- active_idx_o equals idx in every state. It holds the last index in FINISH and IDLE until the next start.
- Latency: start_i sampled at cycle 0 with every child responding in its first WAIT cycle -> child_start_o[k] at cycle 2k+1, done_o at cycle 2*NUM_CHILD+1 (cycle 11 for the default).
- Boundary conditions:
  - start_i while busy: ignored, no queuing.
  - start_i asserted in the same cycle as done_o (FINISH): ignored. It is accepted only in IDLE, one cycle later at the earliest.
  - child_done_i on any bit other than idx: ignored in all states, including during ISSUE.
  - child_done_i[idx] already high in ISSUE: not counted. It is counted only if still high in WAIT.
  - child_done_i[idx] high in the same cycle that the timer reaches TIMEOUT_CYCLES-1: done wins, no error.
  - NUM_CHILD=1: idx stays 0; a single ISSUE/WAIT pass, then FINISH.
  - Timeout on child k: children k+1..NUM_CHILD-1 are never started.
- The timer never wraps; it is reset on every entry to ISSUE.

Test Plan:
1. Reset, then start_i pulse at cycle 0; each child_done_i[k] pulsed in the cycle after child_start_o[k] -> child_start_o = 00001, 00010, 00100, 01000, 10000 at cycles 1, 3, 5, 7, 9; done_o=1 at cycle 11; err_o=0; busy_o=1 for cycles 1-11.
2. TIMEOUT_CYCLES=4; child 2 never responds -> child_start_o[2] at cycle 5; WAIT on child 2 runs cycles 6-9; done_o at cycle 10 with err_o=1 and err_idx_o=2; child_start_o[3] and child_start_o[4] never pulse.
3. Timeout race: child_done_i[1] asserted exactly in the last permitted WAIT cycle -> no error; child_start_o[2] is issued on the next cycle.
4. Noise and re-start: child_done_i[4] held high while idx=0, plus start_i pulses during the sequence -> both are ignored; ordering and total latency match scenario 1.
5. Mid-sequence reset: rst asserted in the cycle child_start_o[2] is high -> next cycle all outputs are at reset values. A following start restarts at child 0. A start accepted after a sequence that ended with err_o=1 clears err_o and err_idx_o.
